// File: rtl/acc_cpu_core_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings, FSM state
// encoding, opcode width and a small decode helper.
package acc_cpu_core_pkg;

  // Width of the opcode field at the top of each instruction word
  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_STA = 4'h2;
  localparam logic [OPW-1:0] OP_ADD = 4'h3;
  localparam logic [OPW-1:0] OP_SUB = 4'h4;
  localparam logic [OPW-1:0] OP_JMP = 4'h5;
  localparam logic [OPW-1:0] OP_JZ  = 4'h6;
  localparam logic [OPW-1:0] OP_JN  = 4'h7;
  localparam logic [OPW-1:0] OP_LDI = 4'h8;
  localparam logic [OPW-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_READ   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Opcodes that need a data read and therefore take the extra READ cycle
  function automatic logic is_mem_read(input logic [OPW-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/acc_cpu_core_alu.sv
// Combinational ALU for the accumulator CPU.
//   op      : opcode of the instruction being completed
//   acc     : current accumulator
//   operand : data word read from memory
//   result  : new accumulator value (LDA/ADD/SUB; acc unchanged otherwise)
//   zero    : acc == 0 (JZ condition)
//   neg     : acc sign bit (JN condition)
module acc_cpu_alu
  import acc_cpu_core_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  acc,
  input  logic [DW-1:0]  operand,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           neg
);

  // Accumulator update; arithmetic wraps modulo 2^DW with no flags kept
  always_comb begin
    result = acc;
    case (op)
      OP_LDA:  result = operand;
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      default: result = acc;
    endcase
  end

  assign zero = (acc == '0);
  assign neg  = acc[DW-1];

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle fetch/decode/execute controller for a 16-bit accumulator
// machine driving a synchronous-read RAM.
//   clk, rst            : clock, synchronous active-high reset
//   mem_addr/load/d     : RAM address, write enable, write data
//   mem_q               : RAM read data, valid the cycle after mem_addr
//   halted, pc, acc     : debug/status outputs
module acc_cpu_core
  import acc_cpu_core_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_load,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc
);

  localparam logic [AW-1:0] RESET_PC_V = AW'(RESET_PC);

  state_e          state_r, state_s;
  logic [AW-1:0]   pc_r, pc_s;
  logic [DW-1:0]   acc_r, acc_s;
  logic [DW-1:0]   ir_r, ir_s;
  logic            halted_r, halted_s;
  logic            mem_load_s;

  logic [OPW-1:0]  op_s;
  logic [AW-1:0]   operand_s;
  logic [DW-1:0]   alu_result_s;
  logic            alu_zero_s;
  logic            alu_neg_s;

  assign op_s      = ir_r[DW-1:AW];
  assign operand_s = ir_r[AW-1:0];

  acc_cpu_alu #(.DW(DW)) u_alu (
    .op      (op_s),
    .acc     (acc_r),
    .operand (mem_q),
    .result  (alu_result_s),
    .zero    (alu_zero_s),
    .neg     (alu_neg_s)
  );

  // Next-state, register updates and bus outputs decoded from the current state
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    acc_s      = acc_r;
    ir_s       = ir_r;
    halted_s   = halted_r;
    mem_addr   = '0;
    mem_load_s = 1'b0;
    mem_d      = acc_r;
    case (state_r)
      S_FETCH: begin
        mem_addr = pc_r;
        state_s  = S_DECODE;
      end
      S_DECODE: begin
        ir_s    = mem_q;
        pc_s    = pc_r + AW'(1);
        state_s = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem_read(op_s)) begin
          mem_addr = operand_s;
          state_s  = S_READ;
        end else begin
          state_s = S_FETCH;
          case (op_s)
            OP_STA: begin
              mem_addr   = operand_s;
              mem_load_s = 1'b1;
            end
            OP_JMP: pc_s = operand_s;
            OP_JZ: begin
              if (alu_zero_s) pc_s = operand_s;
              else            pc_s = pc_r;
            end
            OP_JN: begin
              if (alu_neg_s) pc_s = operand_s;
              else           pc_s = pc_r;
            end
            OP_LDI: acc_s = {{(DW-AW){1'b0}}, operand_s};
            OP_HLT: begin
              halted_s = 1'b1;
              state_s  = S_HALT;
            end
            default: state_s = S_FETCH;
          endcase
        end
      end
      S_READ: begin
        acc_s   = alu_result_s;
        state_s = S_FETCH;
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_FETCH;
    endcase
  end

  // The write strobe is suppressed while reset is asserted so an abandoned STA never lands
  assign mem_load = mem_load_s && !rst;

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_FETCH;
      pc_r     <= RESET_PC_V;
      acc_r    <= '0;
      ir_r     <= '0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      acc_r    <= acc_s;
      ir_r     <= ir_s;
      halted_r <= halted_s;
    end
  end

  assign halted = halted_r;
  assign pc     = pc_r;
  assign acc    = acc_r;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: behavioural RAM plus an
// instruction-level reference model run in lockstep with the DUT.
module tb_acc_cpu_core;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_load;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic          halted;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;

  always #5 clk = ~clk;

  acc_cpu_core #(.AW(AW), .DW(DW), .RESET_PC(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_load (mem_load),
    .mem_d    (mem_d),
    .mem_q    (mem_q),
    .halted   (halted),
    .pc       (pc),
    .acc      (acc)
  );

  // Behavioural synchronous RAM with a bench-side load port
  logic [DW-1:0] ram [0:4095];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;

  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_load) ram[mem_addr] <= mem_d;
    mem_q <= ram[mem_addr];
  end

  // Reference model state
  logic [DW-1:0] mdl_mem [0:4095];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  logic          m_halt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mdl_mem[a] = d;
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_pc   = '0;
    m_acc  = '0;
    m_halt = 1'b0;
    #1;
  endtask

  // Execute one instruction on the model and follow the DUT through its cycles
  task automatic step_check(input string tag);
    logic [DW-1:0] w;
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] npc;
    logic [DW-1:0] nacc;
    logic          rd;
    int            ncyc;
    w    = mdl_mem[m_pc];
    op   = w[15:12];
    a    = w[11:0];
    rd   = (op == 4'd1) || (op == 4'd3) || (op == 4'd4);
    ncyc = rd ? 4 : 3;
    for (int c = 0; c < ncyc; c++) begin
      logic [AW-1:0] e_addr;
      logic          e_load;
      e_addr = (c == 0) ? m_pc : (((c == 2) && (rd || op == 4'd2)) ? a : 12'd0);
      e_load = (c == 2) && (op == 4'd2);
      chk($sformatf("%s_addr_pc%0h_c%0d", tag, m_pc, c), 32'(mem_addr), 32'(e_addr));
      chk($sformatf("%s_load_pc%0h_c%0d", tag, m_pc, c), 32'(mem_load), 32'(e_load));
      if (e_load) chk($sformatf("%s_stdata_pc%0h", tag, m_pc), 32'(mem_d), 32'(m_acc));
      @(negedge clk);
      #1;
    end
    npc  = m_pc + 12'd1;
    nacc = m_acc;
    case (op)
      4'd1: nacc = mdl_mem[a];
      4'd2: mdl_mem[a] = m_acc;
      4'd3: nacc = m_acc + mdl_mem[a];
      4'd4: nacc = m_acc - mdl_mem[a];
      4'd5: npc = a;
      4'd6: if (m_acc == 16'd0) npc = a;
      4'd7: if (m_acc[15]) npc = a;
      4'd8: nacc = {4'd0, a};
      4'd15: m_halt = 1'b1;
      default: ;
    endcase
    m_pc  = npc;
    m_acc = nacc;
    chk($sformatf("%s_pc", tag), 32'(pc), 32'(m_pc));
    chk($sformatf("%s_acc", tag), 32'(acc), 32'(m_acc));
    chk($sformatf("%s_halted", tag), 32'(halted), 32'(m_halt));
  endtask

  task automatic run_prog(input string tag, input int max_instr);
    for (int i = 0; i < max_instr; i++) begin
      if (m_halt) break;
      step_check(tag);
    end
    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        chk($sformatf("%s_hold_pc", tag), 32'(pc), 32'(m_pc));
        chk($sformatf("%s_hold_halted", tag), 32'(halted), 32'd1);
        chk($sformatf("%s_hold_load", tag), 32'(mem_load), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) put(12'(i), 16'd0);

    // Reset state in the first FETCH
    reset_dut();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_load", 32'(mem_load), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    // LDA/ADD/STA/HLT
    rst = 1'b1;
    put(12'h000, 16'h1010); put(12'h001, 16'h3011);
    put(12'h002, 16'h2012); put(12'h003, 16'hF000);
    put(12'h010, 16'd20);   put(12'h011, 16'd30);
    reset_dut();
    run_prog("p_add", 10);
    chk("p_add_mem12", 32'(ram[12'h012]), 32'd50);
    chk("p_add_acc", 32'(acc), 32'd50);
    chk("p_add_pc", 32'(pc), 32'd4);

    // SUB wrap then JN taken
    rst = 1'b1;
    put(12'h000, 16'h8000); put(12'h001, 16'h4020);
    put(12'h002, 16'h7008); put(12'h008, 16'hF000);
    put(12'h020, 16'd1);
    reset_dut();
    run_prog("p_sub", 10);
    chk("p_sub_acc", 32'(acc), 32'h0000FFFF);

    // Countdown loop
    rst = 1'b1;
    put(12'h000, 16'h8003); put(12'h001, 16'h4040);
    put(12'h002, 16'h6004); put(12'h003, 16'h5001);
    put(12'h004, 16'hF000); put(12'h040, 16'd1);
    reset_dut();
    run_prog("p_loop", 20);
    chk("p_loop_acc", 32'(acc), 32'd0);
    chk("p_loop_pc", 32'(pc), 32'd5);

    // PC wrap from 0xFFF to 0x000
    rst = 1'b1;
    put(12'h000, 16'h5FFF); put(12'hFFF, 16'h0000);
    reset_dut();
    run_prog("p_wrap", 4);

    // Reset during the EXEC cycle of a STA
    rst = 1'b1;
    put(12'h000, 16'h8007); put(12'h001, 16'h2030); put(12'h030, 16'd0);
    reset_dut();
    run_prog("p_rst", 1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("p_rst_load_exec", 32'(mem_load), 32'd1);
    rst = 1'b1;
    #1;
    chk("p_rst_load_forced", 32'(mem_load), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("p_rst_pc", 32'(pc), 32'd0);
    chk("p_rst_addr", 32'(mem_addr), 32'd0);
    chk("p_rst_acc", 32'(acc), 32'd0);
    chk("p_rst_mem30", 32'(ram[12'h030]), 32'd0);

    // Random programs
    for (int p = 0; p < 12; p++) begin
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
        logic [DW-1:0] d;
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
        put(12'h100 + 12'(i), d);
      end
      for (int i = 0; i < 19; i++) begin
        logic [3:0]    op;
        logic [AW-1:0] opnd;
        op = 4'($urandom_range(0, 15));
        if (op >= 4'd1 && op <= 4'd4)      opnd = 12'h100 + 12'($urandom_range(0, 7));
        else if (op >= 4'd5 && op <= 4'd7) opnd = 12'($urandom_range(0, 19));
        else if (op == 4'd8)               opnd = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom);
        else                               opnd = 12'($urandom);
        put(12'(i), {op, opnd});
      end
      put(12'd19, 16'hF000);
      reset_dut();
      run_prog($sformatf("rnd%0d", p), 40);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd%0d_mem%0d", p, i), 32'(ram[12'h100 + 12'(i)]), 32'(mdl_mem[12'h100 + 12'(i)]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
